param_rf: RTL
=============

Name: param_rf

Overview:
- Parametrised successor to the generated single-register-set file.
- REG_COUNT registers of REG_WIDTH bits behind one software access port, with hardware update, written strobe and counter mode per register.
- Configurable read pipeline latency and a busy/complete handshake.
- Sits between the host access bridge (software side) and block logic (hardware side).

Parameters:
- ADDR_WIDTH, 4, software word address width.
- DATA_WIDTH, 64, software data width; must be >= REG_WIDTH.
- REG_COUNT, 6, number of implemented registers, 2..2**ADDR_WIDTH.
- REG_WIDTH, 16, width of every register.
- READ_LATENCY, 1, read_en-to-access_complete delay in cycles, legal range 1..4.
- ID_VALUE, 16'hABCD, constant returned by register 0 (read-only).
- RESET_VALUE, 0, reset value of registers 1..REG_COUNT-1.
- COUNTER_MASK, 0, bit i set: register i is a counter driven by hw_inc[i]; bit 0 ignored.

Ports:
- clk  in  1  clock.
- res  in  1  reset, synchronous, active-high.
- address  in  ADDR_WIDTH  software word address.
- read_en  in  1  software read strobe, one cycle.
- write_en  in  1  software write strobe, one cycle.
- write_data  in  DATA_WIDTH  software write data; low REG_WIDTH bits used.
- read_data  out  DATA_WIDTH  read result, zero-extended.
- access_complete  out  1  one-cycle completion pulse.
- invalid_address  out  1  qualifies access_complete; address >= REG_COUNT.
- busy  out  1  read in flight; strobes ignored.
- hw_next  in  REG_COUNT*REG_WIDTH  flattened hardware load values; slice i is register i.
- hw_wen  in  REG_COUNT  hardware load enables.
- hw_inc  in  REG_COUNT  counter increment enables.
- reg_q  out  REG_COUNT*REG_WIDTH  flattened current register values.
- written  out  REG_COUNT  one-cycle pulse after a software write lands.

Behaviour:
- Reset (res high at posedge): registers 1..N-1 load RESET_VALUE, register 0 reads ID_VALUE. read_data=0, access_complete=0, invalid_address=0, busy=0, written=0. A read in flight is discarded and produces no completion.
- Accept: a strobe is accepted when busy=0. Strobes while busy=1 are dropped silently. read_en and write_en both high: the write is performed and the read is ignored.
- Write:
  - Register updated at the accepting edge.
  - access_complete=1 and written[i]=1 in the next cycle (latency 1).
  - read_data is unchanged.
  - Writes to register 0 are ignored but still complete; invalid_address=0.
- Read:
  - Address and data are captured at accept; busy=1 from the next cycle until completion.
  - access_complete pulses READ_LATENCY cycles after accept. The value returned is the register value at the accept edge.
  - read_data holds until the next read completion.
  - With READ_LATENCY=1, busy is never asserted and back-to-back reads are allowed.
- Invalid address: address >= REG_COUNT completes with the normal latency, invalid_address=1 for that one cycle, and read_data=0. No register or written bit changes.
- Register update priority, per register per cycle: software write > hw_wen (loads hw_next) > hw_inc (counter registers only; +1, wraps all-ones to 0) > hold.
- hw_inc on non-counter registers is ignored. hw_wen[0] and hw_inc[0] are ignored.
- reg_q is registered; it reflects an update one cycle after the accepting edge.

Optional Feature:
- Macro: PARAM_RF_PARITY_EN.
- Defined:
  - Each register stores an even-parity bit computed on every update.
  - Each read recomputes parity. On mismatch, read_data bit DATA_WIDTH-1 is set together with access_complete.
  - A sticky parity_err output (1 bit, reset 0) is added; it clears on res or on a software write to the failing register.
  - Register 0 is never flagged.
- Undefined: no parity storage, no parity_err port, and bit DATA_WIDTH-1 is always zero-extended.

Test Plan:
- Reset, then read address 0 with READ_LATENCY=3: busy=1 for 2 cycles, access_complete on cycle 3, read_data=64'h000000000000ABCD.
- Write 64'h555AAA555AAA555A to addresses 1..5: each completes next cycle with written[i]=1 and reg_q slice i=16'h555A. Then write address 0: ID is unchanged and no written pulse.
- Same cycle, write 16'h1111 to address 2 with hw_wen[2]=1 and hw_next=16'h2222: reg 2 becomes 16'h1111. Next cycle, hw_wen only: reg 2 becomes 16'h2222.
- COUNTER_MASK bit 3 set, reg 3 written to 16'hFFFE, then 3 cycles of hw_inc[3]=1: values FFFF, 0000, 0001. Repeat with hw_wen[3] and hw_next=16'h0042: wen wins, value 0042.
- Read address 7 (REG_COUNT=6): access_complete with invalid_address=1 and read_data=0. A read_en issued while busy=1 produces no extra completion.
- Assert res in the middle of a READ_LATENCY=4 read: no access_complete, busy=0 on the next cycle, all registers back to RESET_VALUE.

Source files
------------

// File: rtl/param_rf.sv
// param_rf: REG_COUNT x REG_WIDTH register file with software port, hardware load/counter update and pipelined reads.
// Optional PARAM_RF_PARITY_EN adds per-register even parity with a sticky parity_err output.
module param_rf #(
  parameter int                   ADDR_WIDTH   = 4,
  parameter int                   DATA_WIDTH   = 64,
  parameter int                   REG_COUNT    = 6,
  parameter int                   REG_WIDTH    = 16,
  parameter int                   READ_LATENCY = 1,
  parameter logic [REG_WIDTH-1:0] ID_VALUE     = 16'hABCD,
  parameter logic [REG_WIDTH-1:0] RESET_VALUE  = '0,
  parameter logic [REG_COUNT-1:0] COUNTER_MASK = '0
) (
  input  logic                           clk,
  input  logic                           res,
  input  logic [ADDR_WIDTH-1:0]          address,
  input  logic                           read_en,
  input  logic                           write_en,
  input  logic [DATA_WIDTH-1:0]          write_data,
  output logic [DATA_WIDTH-1:0]          read_data,
  output logic                           access_complete,
  output logic                           invalid_address,
  output logic                           busy,
  input  logic [REG_COUNT*REG_WIDTH-1:0] hw_next,
  input  logic [REG_COUNT-1:0]           hw_wen,
  input  logic [REG_COUNT-1:0]           hw_inc,
  output logic [REG_COUNT*REG_WIDTH-1:0] reg_q,
`ifdef PARAM_RF_PARITY_EN
  output logic                           parity_err,
`endif
  output logic [REG_COUNT-1:0]           written
);
  localparam int CW = $clog2(READ_LATENCY + 1);
  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_WIDTH-1:0] nxt [REG_COUNT];
  logic [REG_WIDTH-1:0] cur;
  logic [REG_COUNT-1:0] sel;
  logic [DATA_WIDTH-1:0] rd_val, rd_hold;
  logic [CW-1:0] cnt;
  logic acc_wr, acc_rd, bad, rd_bad;
  always_comb begin
    acc_wr = write_en && !busy;
    acc_rd = read_en && !write_en && !busy;
    bad = int'(address) >= REG_COUNT;
    cur = '0;
    sel = '0;
    for (int i = 0; i < REG_COUNT; i++) begin
      sel[i] = int'(address) == i;
      cur = sel[i] ? regs[i] : cur;
      nxt[i] = regs[i];
      if (i > 0)
        nxt[i] = acc_wr && sel[i] ? write_data[REG_WIDTH-1:0] :
                 hw_wen[i] ? hw_next[i*REG_WIDTH +: REG_WIDTH] :
                 COUNTER_MASK[i] && hw_inc[i] ? regs[i] + REG_WIDTH'(1) : regs[i];
    end
  end
  always_comb begin
    reg_q = '0;
    for (int i = 0; i < REG_COUNT; i++) reg_q[i*REG_WIDTH +: REG_WIDTH] = regs[i];
  end
`ifdef PARAM_RF_PARITY_EN
  logic [REG_COUNT-1:0] par;
  logic [ADDR_WIDTH-1:0] perr_addr;
  logic cur_par, perr_hit;
  always_comb begin
    cur_par = 1'b0;
    for (int i = 0; i < REG_COUNT; i++) cur_par = sel[i] ? par[i] : cur_par;
    perr_hit = !bad && !sel[0] && (cur_par != ^cur);
    rd_val = {perr_hit, {(DATA_WIDTH-1){1'b0}}} | DATA_WIDTH'(cur);
  end
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < REG_COUNT; i++) par[i] <= i == 0 ? ^ID_VALUE : ^RESET_VALUE;
      parity_err <= 1'b0;
      perr_addr <= '0;
    end else begin
      for (int i = 0; i < REG_COUNT; i++) par[i] <= ^nxt[i];
      if (acc_rd && perr_hit) begin
        parity_err <= 1'b1;
        perr_addr <= address;
      end else if (acc_wr && address == perr_addr) parity_err <= 1'b0;
    end
  end
`else
  assign rd_val = DATA_WIDTH'(cur);
`endif
  always_ff @(posedge clk) begin
    if (res) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= i == 0 ? ID_VALUE : RESET_VALUE;
      read_data <= '0;
      access_complete <= 1'b0;
      invalid_address <= 1'b0;
      busy <= 1'b0;
      written <= '0;
      cnt <= '0;
      rd_hold <= '0;
      rd_bad <= 1'b0;
    end else begin
      regs <= nxt;
      written <= acc_wr ? sel & ~REG_COUNT'(1) : '0;
      access_complete <= 1'b0;
      invalid_address <= 1'b0;
      if (acc_wr) begin
        access_complete <= 1'b1;
        invalid_address <= bad;
      end else if (acc_rd && READ_LATENCY == 1) begin
        access_complete <= 1'b1;
        invalid_address <= bad;
        read_data <= rd_val;
      end else if (acc_rd) begin
        busy <= 1'b1;
        cnt <= CW'(READ_LATENCY - 1);
        rd_hold <= rd_val;
        rd_bad <= bad;
      end else if (busy) begin
        // the read value was captured at accept; only its release is delayed
        cnt <= cnt - CW'(1);
        if (cnt == CW'(1)) begin
          busy <= 1'b0;
          access_complete <= 1'b1;
          invalid_address <= rd_bad;
          read_data <= rd_hold;
        end
      end
    end
  end
endmodule
